// File: rtl/pixel_lane_scheduler.sv
// Round-robin pixel dispatcher over parallel compute lanes with in-order
// collection, 24->32 bit packing and a video AXI-Stream output.
module pixel_lane_scheduler #(
    parameter int N_LANES = 4,
    parameter int X_PIX   = 640,
    parameter int Y_SIZE  = 480,
    parameter int CW      = 11,
    parameter int MAX_OUT = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    output logic [N_LANES-1:0]     lane_req_valid,
    input  logic [N_LANES-1:0]     lane_req_ready,
    output logic [CW-1:0]          req_x,
    output logic [CW-1:0]          req_y,
    input  logic [N_LANES-1:0]     lane_res_valid,
    output logic [N_LANES-1:0]     lane_res_ready,
    input  logic [24*N_LANES-1:0]  lane_res_data,
    output logic [31:0]            out_stream_tdata,
    output logic                   out_stream_tvalid,
    input  logic                   out_stream_tready,
    output logic                   out_stream_tuser,
    output logic                   out_stream_tlast,
    output logic                   busy,
    output logic                   frame_done
);

    localparam int X_WORDS = X_PIX * 3 / 4;
    localparam int LW = $clog2(N_LANES);
    localparam int OW = $clog2(MAX_OUT + 1);
    localparam int WW = $clog2(X_WORDS + 1);
    localparam int YW = $clog2(Y_SIZE + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t        state_q;
    logic          busy_q, done_q;
    logic [CW-1:0] dx_q, dx_d, dy_q, dy_d;
    logic [LW-1:0] dlane_q, dlane_d, clane_q, clane_d;
    logic [OW-1:0] out_q, out_d;
    logic [1:0]    phase_q, phase_d;
    logic [23:0]   res_q, res_d;
    logic [31:0]   tdata_q, tdata_d;
    logic          tvalid_q, tvalid_d, tuser_q, tuser_d;
    logic          tlast_q, tlast_d, tend_q, tend_d;
    logic [WW-1:0] wcnt_q, wcnt_d;
    logic [YW-1:0] lcnt_q, lcnt_d;

    logic          req_ok, dhs, last_px, pk_ok, take, fin_hs, start;
    logic [23:0]   pix;
    logic [31:0]   word;

    always_comb begin
        req_ok = (state_q == RUN) && (out_q < OW'(MAX_OUT));
        lane_req_valid = '0;
        if (req_ok) lane_req_valid[dlane_q] = 1'b1;
        dhs = req_ok && lane_req_ready[dlane_q];
        last_px = (dx_q == CW'(X_PIX - 1)) && (dy_q == CW'(Y_SIZE - 1));
        // Phase 0 only fills the residue, so it never waits on the sink
        pk_ok = (state_q != IDLE) &&
                ((phase_q == 2'd0) || !tvalid_q || out_stream_tready);
        lane_res_ready = '0;
        if (pk_ok) lane_res_ready[clane_q] = 1'b1;
        take = pk_ok && lane_res_valid[clane_q];
        pix = lane_res_data[24*int'(clane_q) +: 24];
        fin_hs = tvalid_q && out_stream_tready && tend_q;
        start = enable && ((state_q == IDLE) ||
                           ((state_q == DRAIN) && fin_hs));
    end

    always_comb begin
        dx_d = dx_q;
        dy_d = dy_q;
        dlane_d = dlane_q;
        clane_d = clane_q;
        out_d = out_q;
        phase_d = phase_q;
        res_d = res_q;
        word = 32'h0;
        tdata_d = tdata_q;
        tvalid_d = tvalid_q;
        tuser_d = tuser_q;
        tlast_d = tlast_q;
        tend_d = tend_q;
        wcnt_d = wcnt_q;
        lcnt_d = lcnt_q;
        if (dhs) begin
            dlane_d = dlane_q + 1'b1;
            if (dx_q == CW'(X_PIX - 1)) begin
                dx_d = '0;
                dy_d = (dy_q == CW'(Y_SIZE - 1)) ? '0 : dy_q + 1'b1;
            end else begin
                dx_d = dx_q + 1'b1;
            end
        end
        if (dhs && !take) out_d = out_q + 1'b1;
        else if (!dhs && take) out_d = out_q - 1'b1;
        if (take) begin
            clane_d = clane_q + 1'b1;
            phase_d = phase_q + 2'd1;
            case (phase_q)
                2'd0: res_d = pix;
                2'd1: begin
                    word = {pix[7:0], res_q};
                    res_d = {8'h00, pix[23:8]};
                end
                2'd2: begin
                    word = {pix[15:0], res_q[15:0]};
                    res_d = {16'h0000, pix[23:16]};
                end
                default: word = {pix, res_q[7:0]};
            endcase
        end
        if (tvalid_q && out_stream_tready) tvalid_d = 1'b0;
        if (take && (phase_q != 2'd0)) begin
            tvalid_d = 1'b1;
            tdata_d = word;
            tuser_d = (wcnt_q == '0) && (lcnt_q == '0);
            tlast_d = (wcnt_q == WW'(X_WORDS - 1));
            tend_d = tlast_d && (lcnt_q == YW'(Y_SIZE - 1));
            if (tlast_d) begin
                wcnt_d = '0;
                lcnt_d = (lcnt_q == YW'(Y_SIZE - 1)) ? '0 : lcnt_q + 1'b1;
            end else begin
                wcnt_d = wcnt_q + 1'b1;
            end
        end
        if (start) begin
            dlane_d = '0;
            clane_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (enable) begin
                    state_q <= RUN;
                    busy_q <= 1'b1;
                end
                RUN: if (dhs && last_px) state_q <= DRAIN;
                DRAIN: if (fin_hs) begin
                    done_q <= 1'b1;
                    busy_q <= enable;
                    state_q <= enable ? RUN : IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dx_q <= '0;
            dy_q <= '0;
            dlane_q <= '0;
            clane_q <= '0;
            out_q <= '0;
            phase_q <= '0;
            res_q <= '0;
            tdata_q <= '0;
            tvalid_q <= 1'b0;
            tuser_q <= 1'b0;
            tlast_q <= 1'b0;
            tend_q <= 1'b0;
            wcnt_q <= '0;
            lcnt_q <= '0;
        end else begin
            dx_q <= dx_d;
            dy_q <= dy_d;
            dlane_q <= dlane_d;
            clane_q <= clane_d;
            out_q <= out_d;
            phase_q <= phase_d;
            res_q <= res_d;
            tdata_q <= tdata_d;
            tvalid_q <= tvalid_d;
            tuser_q <= tuser_d;
            tlast_q <= tlast_d;
            tend_q <= tend_d;
            wcnt_q <= wcnt_d;
            lcnt_q <= lcnt_d;
        end
    end

    assign req_x = dx_q;
    assign req_y = dy_q;
    assign out_stream_tdata = tdata_q;
    assign out_stream_tvalid = tvalid_q;
    assign out_stream_tuser = tuser_q;
    assign out_stream_tlast = tlast_q;
    assign busy = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_pixel_lane_scheduler.sv
// Bench for pixel_lane_scheduler: lane/sink models, byte-stream scoreboard,
// vector table and multi-cycle corner sequences on a small 8x4 frame.
module tb_pixel_lane_scheduler;

    localparam int NL = 4;
    localparam int XP = 8;
    localparam int YS = 4;
    localparam int CW = 11;
    localparam int MO = 8;
    localparam int XW = XP * 3 / 4;
    localparam int PPF = XP * YS;
    localparam int WPF = PPF * 3 / 4;

    logic            clk, rst, enable;
    logic [NL-1:0]   lane_req_valid, lane_req_ready;
    logic [CW-1:0]   req_x, req_y;
    logic [NL-1:0]   lane_res_valid, lane_res_ready;
    logic [24*NL-1:0] lane_res_data;
    logic [31:0]     tdata;
    logic            tvalid, tready, tuser, tlast, busy, frame_done;

    pixel_lane_scheduler #(
        .N_LANES(NL), .X_PIX(XP), .Y_SIZE(YS), .CW(CW), .MAX_OUT(MO)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .lane_req_valid(lane_req_valid), .lane_req_ready(lane_req_ready),
        .req_x(req_x), .req_y(req_y),
        .lane_res_valid(lane_res_valid), .lane_res_ready(lane_res_ready),
        .lane_res_data(lane_res_data),
        .out_stream_tdata(tdata), .out_stream_tvalid(tvalid),
        .out_stream_tready(tready), .out_stream_tuser(tuser),
        .out_stream_tlast(tlast), .busy(busy), .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [23:0] d; int due; } lres_t;
    typedef struct { logic [31:0] d; logic u; logic l; } cap_t;
    typedef struct { int idx; logic [31:0] d; logic u; logic l; } vec_t;

    lres_t lq[NL][$];
    cap_t  wcap[$];
    vec_t  vt[9];

    int nchk, nerr, cyc;
    int lat_min, lat_max, rdy_pct, lreq_pct, stall_lane, stall_until;
    int dk, coll, wk, done_cnt, tuser_cnt, tlast_cnt, max_out, req_seen;
    int base, wbase;
    bit req_hold, out_hold;
    int hold_lane;
    logic [CW-1:0] hold_x, hold_y;
    logic [31:0] hold_d;
    logic hold_u, hold_l;

    task automatic chk_eq(input string nm, input longint act, input longint exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_le(input string nm, input longint act, input longint lim);
        nchk++;
        if (act > lim) begin
            nerr++;
            $display("FAIL %s: actual=%0d required<=%0d", nm, act, lim);
        end
    endtask

    function automatic logic [23:0] pix_of(input int k);
        logic [7:0] x, y;
        x = 8'(k % XP);
        y = 8'(k / XP);
        return {x, y, 8'hA5};
    endfunction

    // Frame as a little-endian byte stream of 24-bit pixels, cut into words
    function automatic logic [31:0] exp_word(input int w);
        logic [31:0] r;
        logic [23:0] p;
        int b;
        r = '0;
        for (int j = 0; j < 4; j++) begin
            b = 4 * w + j;
            p = pix_of(b / 3);
            r[8*j +: 8] = p[8*(b%3) +: 8];
        end
        return r;
    endfunction

    task automatic reset_model();
        for (int i = 0; i < NL; i++) lq[i].delete();
        dk = 0;
        coll = 0;
        wk = 0;
        req_hold = 0;
        out_hold = 0;
    endtask

    task automatic observe();
        int k;
        if (req_hold) begin
            chk_eq("req_hold_v", lane_req_valid, 1 << hold_lane);
            chk_eq("req_hold_x", req_x, hold_x);
            chk_eq("req_hold_y", req_y, hold_y);
        end
        if (out_hold) begin
            chk_eq("out_hold_v", tvalid, 1);
            chk_eq("out_hold_d", tdata, hold_d);
            chk_eq("out_hold_u", tuser, hold_u);
            chk_eq("out_hold_l", tlast, hold_l);
        end
        req_hold = 0;
        out_hold = 0;
        chk_le("req_onehot", $countones(lane_req_valid), 1);
        if (lane_req_valid != '0) req_seen++;
        for (int i = 0; i < NL; i++) begin
            if (lane_req_valid[i] && lane_req_ready[i]) begin
                k = dk % PPF;
                chk_eq("disp_lane", i, dk % NL);
                chk_eq("disp_x", req_x, k % XP);
                chk_eq("disp_y", req_y, k / XP);
                lq[i].push_back('{{req_x[7:0], req_y[7:0], 8'hA5},
                    cyc + int'($urandom_range(lat_max, lat_min))});
                dk++;
            end else if (lane_req_valid[i]) begin
                req_hold = 1;
                hold_lane = i;
                hold_x = req_x;
                hold_y = req_y;
            end
        end
        for (int i = 0; i < NL; i++) begin
            if (lane_res_valid[i] && lane_res_ready[i]) begin
                chk_eq("coll_lane", i, coll % NL);
                void'(lq[i].pop_front());
                coll++;
            end
        end
        chk_le("outstanding", dk - coll, MO);
        if (dk - coll > max_out) max_out = dk - coll;
        if (tvalid && tready) begin
            k = wk % WPF;
            chk_eq("word_data", tdata, exp_word(k));
            chk_eq("word_tuser", tuser, k == 0);
            chk_eq("word_tlast", tlast, (k % XW) == XW - 1);
            if (tuser) tuser_cnt++;
            if (tlast) tlast_cnt++;
            wcap.push_back('{tdata, tuser, tlast});
            wk++;
        end else if (tvalid) begin
            out_hold = 1;
            hold_d = tdata;
            hold_u = tuser;
            hold_l = tlast;
        end
        if (frame_done) begin
            done_cnt++;
            chk_eq("done_align", wk % WPF, 0);
            chk_eq("done_nonempty", wk > 0, 1);
        end
    endtask

    task automatic drive();
        bit v;
        for (int i = 0; i < NL; i++) begin
            lane_req_ready[i] = ($urandom_range(99, 0) < lreq_pct);
            v = (lq[i].size() > 0) && !(i == stall_lane && cyc < stall_until);
            if (v) v = (lq[i][0].due <= cyc);
            lane_res_valid[i] = v;
            lane_res_data[24*i +: 24] = v ? lq[i][0].d : 24'h0;
        end
        tready = ($urandom_range(99, 0) < rdy_pct);
    endtask

    task automatic step();
        @(negedge clk);
        if (!rst) observe();
        @(posedge clk);
        cyc++;
        #1;
        drive();
    endtask

    task automatic check_zero(input string nm);
        chk_eq({nm, "_lanes"}, {lane_req_valid, lane_res_ready, req_x, req_y}, 0);
        chk_eq({nm, "_out"}, {tdata, tvalid, tuser, tlast, busy, frame_done}, 0);
    endtask

    task automatic async_reset(input string nm);
        #2 rst = 1'b1;
        #1 check_zero(nm);
        reset_model();
        repeat (3) step();
        rst = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, input string nm);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            step();
            n++;
        end
        chk_eq(nm, done_cnt, target);
    endtask

    task automatic wait_line(input int lines, input int budget, input string nm);
        int n = 0;
        while ((wk % WPF) < lines * XW && n < budget) begin
            step();
            n++;
        end
        chk_le(nm, n, budget - 1);
    endtask

    initial begin
        vt[0] = '{0, 32'hA50000A5, 1'b1, 1'b0};
        vt[1] = '{1, 32'h00A50100, 1'b0, 1'b0};
        vt[2] = '{2, 32'h0300A502, 1'b0, 1'b0};
        vt[3] = '{3, 32'hA50400A5, 1'b0, 1'b0};
        vt[4] = '{4, 32'h00A50500, 1'b0, 1'b0};
        vt[5] = '{5, 32'h0700A506, 1'b0, 1'b1};
        vt[6] = '{6, 32'hA50001A5, 1'b0, 1'b0};
        vt[7] = '{7, 32'h01A50101, 1'b0, 1'b0};
        vt[8] = '{8, 32'h0301A502, 1'b0, 1'b0};
        nchk = 0; nerr = 0; cyc = 0;
        lat_min = 1; lat_max = 1; rdy_pct = 100; lreq_pct = 100;
        stall_lane = -1; stall_until = 0;
        done_cnt = 0; tuser_cnt = 0; tlast_cnt = 0; max_out = 0; req_seen = 0;
        reset_model();
        rst = 1'b1; enable = 1'b0;
        lane_req_ready = '0; lane_res_valid = '0; lane_res_data = '0;
        tready = 1'b0;
        repeat (3) step();
        check_zero("por");
        rst = 1'b0;

        req_seen = 0;
        repeat (100) step();
        chk_eq("idle_no_req", req_seen, 0);
        chk_eq("idle_busy", busy, 0);

        enable = 1'b1;
        repeat (5) step();
        chk_eq("run_busy", busy, 1);
        enable = 1'b0;
        async_reset("async_rst");

        wcap.delete(); tuser_cnt = 0; tlast_cnt = 0; base = done_cnt;
        enable = 1'b1;
        step();
        enable = 1'b0;
        wait_done(base + 1, 1000, "small_done");
        repeat (5) step();
        chk_eq("small_words", wcap.size(), WPF);
        chk_eq("small_tuser", tuser_cnt, 1);
        chk_eq("small_tlast", tlast_cnt, YS);
        chk_eq("small_done_once", done_cnt, base + 1);
        chk_eq("small_busy", busy, 0);
        for (int i = 0; i < 9; i++) begin
            chk_eq($sformatf("vec%0d_d", i), wcap[vt[i].idx].d, vt[i].d);
            chk_eq($sformatf("vec%0d_u", i), wcap[vt[i].idx].u, vt[i].u);
            chk_eq($sformatf("vec%0d_l", i), wcap[vt[i].idx].l, vt[i].l);
        end

        lat_min = 1; lat_max = 20; rdy_pct = 50; lreq_pct = 70;
        base = done_cnt; tlast_cnt = 0; wbase = wk;
        enable = 1'b1;
        wait_done(base + 3, 20000, "rand_frames");
        wait_line(2, 2000, "rand_line2");
        enable = 1'b0;
        wait_done(base + 4, 20000, "drop_done");
        step();
        chk_eq("drop_busy", busy, 0);
        req_seen = 0;
        repeat (50) step();
        chk_eq("drop_no_req", req_seen, 0);
        chk_eq("rand_tlast", tlast_cnt, 4 * YS);
        chk_eq("rand_words", wk - wbase, 4 * WPF);

        lat_min = 2; lat_max = 2; rdy_pct = 100; lreq_pct = 100;
        stall_lane = 2; stall_until = cyc + 200; max_out = 0;
        base = done_cnt; wbase = wk;
        enable = 1'b1;
        step();
        enable = 1'b0;
        repeat (100) step();
        chk_eq("stall_max_out", max_out, MO);
        chk_eq("stall_outstanding", dk - coll, MO);
        chk_eq("stall_no_req", lane_req_valid, 0);
        chk_eq("stall_no_word", tvalid, 0);
        chk_eq("stall_words", wk - wbase, 1);
        wait_done(base + 1, 2000, "stall_done");
        chk_eq("stall_all_words", wk - wbase, WPF);
        stall_lane = -1;

        lat_min = 1; lat_max = 20; rdy_pct = 50; lreq_pct = 70;
        enable = 1'b1;
        wait_line(2, 5000, "rst_line2");
        async_reset("mid_rst");
        wcap.delete(); base = done_cnt;
        repeat (2) step();
        enable = 1'b0;
        wait_done(base + 1, 20000, "rst_done");
        chk_eq("rst_words", wcap.size(), WPF);
        chk_eq("rst_word0", wcap[0].d, 32'hA50000A5);
        chk_eq("rst_word0_u", wcap[0].u, 1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
